// File: rtl/core_seq_ctrl_pkg.sv
// Shared decode constants, state encoding and reset defaults for the
// multi-cycle fetch/execute sequencer.
package core_seq_ctrl_pkg;

    localparam logic [6:0]  OPC_OPIMM        = 7'b0010011;
    localparam logic [2:0]  F3_ADDI          = 3'b000;
    localparam logic [31:0] INST_EBREAK      = 32'h00100073;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h80000000;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_REQ  = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_EXEC       = 3'd3,
        ST_HALT       = 3'd4
    } state_t;

endpackage

// File: rtl/core_seq_ctrl_inst_classify.sv
// Combinational instruction classifier: exactly one of the three outputs is
// high for any instruction word.
module inst_classify
    import core_seq_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_addi,
    output logic        is_ebreak,
    output logic        is_illegal
);

    assign is_addi    = (inst[6:0] == OPC_OPIMM) && (inst[14:12] == F3_ADDI);
    assign is_ebreak  = (inst == INST_EBREAK);
    assign is_illegal = !is_addi && !is_ebreak;

endmodule

// File: rtl/core_seq_ctrl.sv
// Fetch/execute sequencer for the ADDI/EBREAK datapath: owns PC, the
// instruction register, regfile write enable and halt/illegal/timeout status.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic [31:0]      pc,
    output logic [31:0]      inst,
    output logic             rf_wen,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halt,
    output logic             ebreak_hit,
    output logic             illegal,
    output logic             timeout
);

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] wait_cnt;
    logic        is_addi;
    logic        is_ebreak;
    logic        is_illegal;
    logic        in_exec;
    logic        timeout_hit;

    inst_classify u_classify (
        .inst       (inst),
        .is_addi    (is_addi),
        .is_ebreak  (is_ebreak),
        .is_illegal (is_illegal)
    );

    assign in_exec     = (state == ST_EXEC);
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST);

    assign imem_req_valid = (state == ST_FETCH_REQ);
    assign imem_req_addr  = pc;
    assign rf_wen         = in_exec && is_addi;
    assign retire         = in_exec && (is_addi || is_ebreak);
    assign ebreak_hit     = in_exec && is_ebreak;
    assign halt           = (state == ST_HALT);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH_REQ;
            end
            ST_FETCH_REQ: begin
                if (imem_req_ready) state_next = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                // A response in the timeout cycle still wins.
                if (imem_resp_valid)  state_next = ST_EXEC;
                else if (timeout_hit) state_next = ST_HALT;
            end
            ST_EXEC: begin
                if (is_addi) state_next = run ? ST_FETCH_REQ : ST_IDLE;
                else         state_next = ST_HALT;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            inst       <= '0;
            wait_cnt   <= '0;
            retire_cnt <= '0;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH_WAIT) begin
                if (imem_resp_valid) begin
                    inst     <= imem_resp_data;
                    wait_cnt <= '0;
                end else if (timeout_hit) begin
                    timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
            end
            if (rf_wen)                 pc         <= pc + 32'd4;
            if (retire)                 retire_cnt <= retire_cnt + CNT_W'(1);
            if (in_exec && is_illegal)  illegal    <= 1'b1;
        end
    end

endmodule
